// File: rtl/weight_bias_update.sv
// weight_bias_update: parameter store for one layer. Seeds W/B from a Galois LFSR
// after reset, then applies saturating W <= W - dW, B <= B - dB per accepted gradient.
module weight_bias_update #(
  parameter int          NP   = 4,
  parameter int          NC   = 4,
  parameter int          WI   = 4,
  parameter int          WF   = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                                iCLK,
  input  logic                                iRST,
  input  logic                                iValid_AS,
  output logic                                oReady_AS,
  input  logic [NC*NP*(WI+WF)+NC*(WI+WF)-1:0] iData_AS,
  output logic                                oValid_BS,
  input  logic                                iReady_BS,
  output logic [NC*NP*(WI+WF)+NC*(WI+WF)-1:0] oData_BS
);
  localparam int          WD   = WI + WF;
  localparam int          NW   = NC * NP;
  localparam int          N    = NW + NC;
  localparam int          KW   = $clog2(N);
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [KW-1:0] r_k;
  logic          r_valid;
  logic [WD-1:0] r_param [N];
  logic [WD-1:0] w_next  [N];
  logic [WD-1:0] w_seed_val;
  logic          w_accept;

  // Entries 0..NW-1 are weights (packed above the biases), NW..N-1 are biases.
  function automatic int ofs(input int k);
    return (k < NW) ? (NC + k) * WD : (k - NW) * WD;
  endfunction

  function automatic logic [WD-1:0] sat_sub(input logic [WD-1:0] p, input logic [WD-1:0] d);
    logic [WD:0] r;
    r = {p[WD-1], p} - {d[WD-1], d};
    if (r[WD] != r[WD-1]) begin
      sat_sub = r[WD] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
    end else begin
      sat_sub = r[WD-1:0];
    end
  endfunction

  assign w_seed_val = {{WI{r_lfsr[WF-1]}}, r_lfsr[WF-1:0]};
  assign oReady_AS  = (r_state == S_RUN) && (!r_valid || iReady_BS);
  assign w_accept   = iValid_AS && oReady_AS;
  assign oValid_BS  = r_valid;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_next[i] = sat_sub(r_param[i], iData_AS[ofs(i) +: WD]);
    end
  end

  always_comb begin
    oData_BS = '0;
    for (int i = 0; i < N; i++) begin
      oData_BS[ofs(i) +: WD] = r_param[i];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_INIT;
      r_lfsr  <= SEED;
      r_k     <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_param[i] <= '0;
      end
    end else begin
      case (r_state)
        S_INIT: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
              r_param[i] <= w_seed_val;
            end
          end
          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
          if (r_k == KW'(N - 1)) begin
            r_k     <= '0;
            r_state <= S_RUN;
            r_valid <= 1'b1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_RUN: begin
          // An accept re-arms the snapshot even when the old one is published at this edge.
          if (w_accept) begin
            for (int i = 0; i < N; i++) begin
              r_param[i] <= w_next[i];
            end
            r_valid <= 1'b1;
          end else if (r_valid && iReady_BS) begin
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_bias_update.sv
// Bench for weight_bias_update: a value-level parameter model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_weight_bias_update;
  localparam int NP = 2, NC = 2, WI = 4, WF = 4;
  localparam int WD = WI + WF;
  localparam int NW = NC * NP;
  localparam int N  = NW + NC;
  localparam int DW = N * WD;

  typedef int vec_t [N];

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iValid_AS;
  logic          oReady_AS;
  logic [DW-1:0] iData_AS;
  logic          oValid_BS;
  logic          iReady_BS;
  logic [DW-1:0] oData_BS;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: parameter values as plain integers
  bit          m_run;
  bit          m_valid;
  int          m_k;
  logic [15:0] m_lfsr;
  vec_t        m_p;

  weight_bias_update #(.NP(NP), .NC(NC), .WI(WI), .WF(WF), .SEED(16'hACE1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid_AS(iValid_AS), .oReady_AS(oReady_AS),
    .iData_AS(iData_AS), .oValid_BS(oValid_BS), .iReady_BS(iReady_BS), .oData_BS(oData_BS)
  );

  always #5 iCLK = ~iCLK;

  function automatic int ofs(input int k);
    return (k < NW) ? NC * WD + k * WD : (k - NW) * WD;
  endfunction

  function automatic int s8(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  function automatic int sat(input int r);
    if (r > 127) return 127;
    if (r < -128) return -128;
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(input vec_t v);
    logic [DW-1:0] w;
    logic [7:0]    b;
    w = '0;
    for (int k = 0; k < N; k++) begin
      b = v[k][7:0];
      w[ofs(k) +: WD] = b;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_entry(input string name, input int k, input logic [7:0] exp);
    chk(name, DW'(oData_BS[ofs(k) +: WD]), DW'(exp));
  endtask

  task automatic m_reset();
    m_run = 1'b0; m_valid = 1'b0; m_k = 0; m_lfsr = 16'hACE1;
    for (int k = 0; k < N; k++) m_p[k] = 0;
  endtask

  // Reference model, advanced on every rising clock edge
  initial begin : model
    bit rdy;
    m_reset();
    forever begin
      @(posedge iCLK);
      if (iRST) begin
        m_reset();
      end else if (!m_run) begin
        m_p[m_k] = int'($signed(m_lfsr[WF-1:0]));
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        m_k++;
        if (m_k == N) begin
          m_run = 1'b1; m_valid = 1'b1;
        end
      end else begin
        rdy = !m_valid || iReady_BS;
        if (iValid_AS && rdy) begin
          for (int k = 0; k < N; k++) m_p[k] = sat(m_p[k] - s8(iData_AS[ofs(k) +: WD]));
          m_valid = 1'b1;
        end else if (m_valid && iReady_BS) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge
  initial begin : compare
    logic exp_r, exp_v;
    logic [DW-1:0] exp_d;
    @(posedge iCLK);
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        exp_r = 1'b0; exp_v = 1'b0; exp_d = '0;
      end else begin
        exp_r = m_run && (!m_valid || iReady_BS);
        exp_v = m_valid;
        exp_d = pack(m_p);
      end
      chk("cyc_oReady_AS", DW'(oReady_AS), DW'(exp_r));
      chk("cyc_oValid_BS", DW'(oValid_BS), DW'(exp_v));
      chk("cyc_oData_BS", oData_BS, exp_d);
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] g, output int waited, output bit ok);
    bit r;
    iValid_AS = 1'b1; iData_AS = g; waited = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      r = oReady_AS;
      @(posedge iCLK);
      #2;
      waited++;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    iValid_AS = 1'b0;
    chk("send_accepted", DW'(ok), DW'(1'b1));
  endtask

  // Called at +2 after reset release: six silent INIT cycles, then the seeded snapshot
  task automatic init_check(input string tag);
    logic [7:0] ini [N];
    ini = '{8'h01, 8'h00, 8'hF8, 8'hFC, 8'hFE, 8'h07};
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK);
      chk({tag, "_init_ready"}, DW'(oReady_AS), DW'(1'b0));
      chk({tag, "_init_valid"}, DW'(oValid_BS), DW'(1'b0));
    end
    @(negedge iCLK);
    chk({tag, "_init_done_valid"}, DW'(oValid_BS), DW'(1'b1));
    for (int k = 0; k < N; k++) chk_entry($sformatf("%s_init_e%0d", tag, k), k, ini[k]);
  endtask

  initial begin : stim
    vec_t v, sb;
    int   waited;
    bit   ok;
    iRST = 1'b1; iValid_AS = 1'b0; iReady_BS = 1'b0; iData_AS = '0;
    tick(); tick();
    iRST = 1'b0;
    init_check("t1");
    tick();

    // Gradients that land every entry on 1.0
    iReady_BS = 1'b1;
    v = '{1 - 16, 0 - 16, -8 - 16, -4 - 16, -2 - 16, 7 - 16};
    send(pack(v), waited, ok);
    @(negedge iCLK);
    for (int k = 0; k < N; k++) chk_entry($sformatf("t2_one_e%0d", k), k, 8'h10);
    chk("t2_valid", DW'(oValid_BS), DW'(1'b1));
    tick();
    v = '{8, 0, 0, 0, 0, 0};
    send(pack(v), waited, ok);
    @(negedge iCLK);
    chk_entry("t2_w00", 0, 8'h08);
    chk_entry("t2_w01", 1, 8'h10);
    chk_entry("t2_b1", 5, 8'h10);
    tick();

    // Saturation
    v = '{-119, 0, 0, 0, 32, 127};
    send(pack(v), waited, ok);
    @(negedge iCLK);
    chk_entry("t3_w00_set", 0, 8'h7F);
    chk_entry("t3_b0_set", 4, 8'hF0);
    chk_entry("t3_b1_set", 5, 8'h91);
    tick();
    v = '{-128, 0, 0, 0, 127, 127};
    send(pack(v), waited, ok);
    @(negedge iCLK);
    chk_entry("t3_w00_satpos", 0, 8'h7F);
    chk_entry("t3_b0_satneg", 4, 8'h80);
    chk_entry("t3_b1_satneg", 5, 8'h80);
    tick();
    v = '{0, 0, 0, 0, 0, 1};
    send(pack(v), waited, ok);
    iReady_BS = 1'b0;
    @(negedge iCLK);
    chk_entry("t3_b1_min_minus1", 5, 8'h80);
    tick();

    // Backpressure: snapshot held, gradient held off, then publish+accept at one edge
    v = '{1, 1, 1, 1, 1, 1};
    iValid_AS = 1'b1; iData_AS = pack(v);
    sb = '{127, 16, 16, 16, -128, -128};
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      chk("t4_ready_low", DW'(oReady_AS), DW'(1'b0));
      chk("t4_data_held", oData_BS, pack(sb));
      chk("t4_valid_held", DW'(oValid_BS), DW'(1'b1));
    end
    tick();
    iReady_BS = 1'b1;
    @(negedge iCLK);
    chk("t4_ready_up", DW'(oReady_AS), DW'(1'b1));
    tick();
    iValid_AS = 1'b0;
    @(negedge iCLK);
    chk("t4_valid_kept", DW'(oValid_BS), DW'(1'b1));
    sb = '{126, 15, 15, 15, -128, -128};
    chk("t4_data_new", oData_BS, pack(sb));
    tick();

    // Back-to-back gradients against an independent scoreboard
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < N; k++) begin
        v[k] = ((j * 7 + k * 3) % 11) - 5;
        sb[k] = sat(sb[k] - v[k]);
      end
      send(pack(v), waited, ok);
      chk($sformatf("t5_one_cycle_%0d", j), DW'(waited), DW'(1));
    end
    @(negedge iCLK);
    chk("t5_final", oData_BS, pack(sb));

    // Reset mid-RUN with a pending snapshot, then again during INIT
    iRST = 1'b1;
    #1;
    chk("t6_run_rst_valid", DW'(oValid_BS), DW'(1'b0));
    chk("t6_run_rst_ready", DW'(oReady_AS), DW'(1'b0));
    chk("t6_run_rst_data", oData_BS, '0);
    tick();
    iRST = 1'b0;
    tick(); tick(); tick();
    iRST = 1'b1;
    #1;
    chk("t6_init_rst_valid", DW'(oValid_BS), DW'(1'b0));
    chk("t6_init_rst_data", oData_BS, '0);
    tick();
    iRST = 1'b0;
    v = '{1, 1, 1, 1, 1, 1};
    iValid_AS = 1'b1; iData_AS = pack(v);
    init_check("t6");
    tick();
    iValid_AS = 1'b0;
    @(negedge iCLK);
    chk_entry("t6_heldoff_w00", 0, 8'h00);
    chk_entry("t6_heldoff_w10", 2, 8'hF7);
    chk_entry("t6_heldoff_b1", 5, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
